// File: rtl/credit_receiver_fifo.sv
// Receive end of a credit-based link: DEPTH-entry buffer, multi-bit credit counter,
// one credit returned per cycle. Optional sticky overflow_err via CREDIT_RECEIVER_OVERFLOW_CHECK_EN.
module credit_receiver_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_sender_in_reset,
  output logic             push_receiver_in_reset,
  input  logic             push_credit_stall,
  output logic             push_credit,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic             pop_valid,
  output logic [WIDTH-1:0] pop_data,
  input  logic [CW-1:0]    credit_initial,
  input  logic [CW-1:0]    credit_withhold,
  output logic [CW-1:0]    credit_count,
  output logic             credit_available
`ifdef CREDIT_RECEIVER_OVERFLOW_CHECK_EN
  ,
  output logic             overflow_err
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    occupancy;

  logic lrst;
  logic wr_en;
  logic deq;
  logic buf_full;
  logic buf_empty;

  // Handshake: a beat moves on pop_valid & pop_ready; push_valid has no
  // back-pressure, the sender may only assert it while holding a credit.
  assign lrst                   = rst | push_sender_in_reset;
  assign push_receiver_in_reset = rst;

  assign buf_full  = (occupancy == DEPTH_C);
  assign buf_empty = (occupancy == '0);

  assign credit_available = (credit_count > credit_withhold);
  assign push_credit      = credit_available & ~push_credit_stall & ~lrst;

  assign pop_valid = ~buf_empty & ~lrst;
  assign pop_data  = mem[rd_ptr];

  // Write is judged against registered occupancy, so a same-cycle dequeue
  // on a full buffer does not make room for it.
  assign wr_en = push_valid & ~lrst & ~buf_full;
  assign deq   = pop_valid & pop_ready;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (lrst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (deq) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (wr_en && !deq) begin
        occupancy <= occupancy + CW'(1);
      end else if (deq && !wr_en) begin
        occupancy <= occupancy - CW'(1);
      end
    end
  end

  // Dequeue returns a credit to the pool, push_credit hands one out; both
  // together cancel. Clamped to 0..DEPTH.
  always_ff @(posedge clk) begin
    if (lrst) begin
      credit_count <= credit_initial;
    end else if (deq && !push_credit) begin
      if (credit_count != DEPTH_C) begin
        credit_count <= credit_count + CW'(1);
      end
    end else if (push_credit && !deq) begin
      if (credit_count != '0) begin
        credit_count <= credit_count - CW'(1);
      end
    end
  end

`ifdef CREDIT_RECEIVER_OVERFLOW_CHECK_EN
  always_ff @(posedge clk) begin
    if (lrst) begin
      overflow_err <= 1'b0;
    end else if ((push_valid && buf_full) ||
                 (deq && !push_credit && (credit_count == DEPTH_C))) begin
      overflow_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_credit_receiver_fifo.sv
// Bench for credit_receiver_fifo: queue-based link model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_credit_receiver_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic             push_sender_in_reset;
  logic             push_receiver_in_reset;
  logic             push_credit_stall;
  logic             push_credit;
  logic             push_valid;
  logic [WIDTH-1:0] push_data;
  logic             pop_ready;
  logic             pop_valid;
  logic [WIDTH-1:0] pop_data;
  logic [CW-1:0]    credit_initial;
  logic [CW-1:0]    credit_withhold;
  logic [CW-1:0]    credit_count;
  logic             credit_available;
`ifdef CREDIT_RECEIVER_OVERFLOW_CHECK_EN
  logic             overflow_err;
`endif

  always #5 clk = ~clk;

  credit_receiver_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .push_sender_in_reset   (push_sender_in_reset),
    .push_receiver_in_reset (push_receiver_in_reset),
    .push_credit_stall      (push_credit_stall),
    .push_credit            (push_credit),
    .push_valid             (push_valid),
    .push_data              (push_data),
    .pop_ready              (pop_ready),
    .pop_valid              (pop_valid),
    .pop_data               (pop_data),
    .credit_initial         (credit_initial),
    .credit_withhold        (credit_withhold),
    .credit_count           (credit_count),
    .credit_available       (credit_available)
`ifdef CREDIT_RECEIVER_OVERFLOW_CHECK_EN
    ,
    .overflow_err           (overflow_err)
`endif
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [WIDTH-1:0] exp_q[$];
  int m_cnt = 0;
  bit m_ovf = 1'b0;
  bit m_deq, m_crd, m_full;

  always @(posedge clk) begin
    if (rst || push_sender_in_reset) begin
      exp_q.delete();
      m_cnt = int'(credit_initial);
      m_ovf = 1'b0;
    end else begin
      m_full = (exp_q.size() == DEPTH);
      m_deq  = (exp_q.size() != 0) && pop_ready;
      m_crd  = (m_cnt > int'(credit_withhold)) && !push_credit_stall;
      if (push_valid && m_full) m_ovf = 1'b1;
      if (m_deq && !m_crd && m_cnt == DEPTH) m_ovf = 1'b1;
      if (m_deq) void'(exp_q.pop_front());
      if (push_valid && !m_full) exp_q.push_back(push_data);
      m_cnt = m_cnt + int'(m_deq) - int'(m_crd);
      if (m_cnt > DEPTH) m_cnt = DEPTH;
      if (m_cnt < 0) m_cnt = 0;
    end
  end

  // Compare process: outputs are checked mid-cycle against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      bit lr, av, pv;
      lr = rst || push_sender_in_reset;
      av = (m_cnt > int'(credit_withhold));
      pv = (exp_q.size() != 0) && !lr;
      chk("cmp_count", 32'(credit_count), 32'(m_cnt));
      chk("cmp_avail", 32'(credit_available), 32'(av));
      chk("cmp_credit", 32'(push_credit), 32'(av && !push_credit_stall && !lr));
      chk("cmp_pop_valid", 32'(pop_valid), 32'(pv));
      chk("cmp_recv_rst", 32'(push_receiver_in_reset), 32'(rst));
      if (pv) chk("cmp_pop_data", 32'(pop_data), 32'(exp_q[0]));
`ifdef CREDIT_RECEIVER_OVERFLOW_CHECK_EN
      chk("cmp_ovf", 32'(overflow_err), 32'(m_ovf));
`endif
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; push_sender_in_reset = 1'b0; push_credit_stall = 1'b0;
    push_valid = 1'b0; push_data = '0; pop_ready = 1'b0;
    credit_initial = CW'(4); credit_withhold = '0;
    tick();
    cmp_en = 1'b1;
    tick();
    @(negedge clk);
    chk("reset_count", 32'(credit_count), 32'd4);
    chk("reset_recv_rst", 32'(push_receiver_in_reset), 32'd1);
    chk("reset_pop_valid", 32'(pop_valid), 32'd0);
    chk("reset_credit", 32'(push_credit), 32'd0);
    tick();

    // Four credits stream out after release.
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("release_count", 32'(credit_count), 32'(4 - i));
      chk("release_credit", 32'(push_credit), 32'(i < 4));
      chk("release_avail", 32'(credit_available), 32'(i < 4));
      tick();
    end

    // Back-to-back pushes with pop_ready high.
    push_valid = 1'b1; push_data = 8'hA1; pop_ready = 1'b1;
    @(negedge clk); chk("lat_first", 32'(pop_valid), 32'd0); tick();
    push_data = 8'hA2;
    @(negedge clk);
    chk("pop_a1_valid", 32'(pop_valid), 32'd1);
    chk("pop_a1", 32'(pop_data), 32'hA1);
    chk("pop_a1_credit", 32'(push_credit), 32'd0);
    tick();
    push_data = 8'hA3;
    @(negedge clk);
    chk("pop_a2", 32'(pop_data), 32'hA2);
    chk("pop_a2_credit", 32'(push_credit), 32'd1);
    chk("pop_a2_count", 32'(credit_count), 32'd1);
    tick();
    push_valid = 1'b0;
    @(negedge clk);
    chk("pop_a3", 32'(pop_data), 32'hA3);
    chk("pop_a3_credit", 32'(push_credit), 32'd1);
    tick();
    @(negedge clk);
    chk("deq_credit_cancel", 32'(credit_count), 32'd1);
    chk("drained", 32'(pop_valid), 32'd0);
    tick();
    @(negedge clk); chk("count_zero", 32'(credit_count), 32'd0);
    tick();

    // Dequeue while credit return is stalled raises the count.
    push_credit_stall = 1'b1; pop_ready = 1'b0;
    push_valid = 1'b1; push_data = 8'hB1; tick();
    push_data = 8'hB2; tick();
    push_valid = 1'b0; pop_ready = 1'b1; tick();
    @(negedge clk);
    chk("stall_count1", 32'(credit_count), 32'd1);
    chk("stall_no_credit", 32'(push_credit), 32'd0);
    tick();
    @(negedge clk); chk("stall_count2", 32'(credit_count), 32'd2);
    push_credit_stall = 1'b0;
    tick(); tick(); tick();

    // Fill, then overflow push, then push during full+dequeue.
    pop_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      push_valid = 1'b1; push_data = 8'(8'hC0 + k); tick();
    end
    push_data = 8'hFF;
    @(negedge clk); chk("full_head", 32'(pop_data), 32'hC0);
    tick();
`ifdef CREDIT_RECEIVER_OVERFLOW_CHECK_EN
    @(negedge clk); chk("ovf_set", 32'(overflow_err), 32'd1);
`endif
    push_data = 8'hEE; pop_ready = 1'b1; tick();
    push_valid = 1'b0;
    @(negedge clk); chk("full_after_deq", 32'(pop_data), 32'hC1);
    tick(); tick(); tick();
    @(negedge clk); chk("full_drop_empty", 32'(pop_valid), 32'd0);
`ifdef CREDIT_RECEIVER_OVERFLOW_CHECK_EN
    chk("ovf_sticky", 32'(overflow_err), 32'd1);
`endif
    tick(); tick(); tick(); tick();

    // Withhold limits credits issued.
    rst = 1'b1; pop_ready = 1'b0; credit_withhold = CW'(2);
    tick(); tick();
`ifdef CREDIT_RECEIVER_OVERFLOW_CHECK_EN
    @(negedge clk); chk("ovf_cleared", 32'(overflow_err), 32'd0);
    tick();
`endif
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("withhold_credit", 32'(push_credit), 32'(i < 2));
      chk("withhold_count", 32'(credit_count), 32'((i < 2) ? 4 - i : 2));
      tick();
    end
    credit_withhold = CW'(3);
    @(negedge clk);
    chk("withhold_raise_credit", 32'(push_credit), 32'd0);
    chk("withhold_raise_avail", 32'(credit_available), 32'd0);
    tick();
    credit_withhold = CW'(1);
    tick();

    // Sender reset pulse flushes three buffered entries.
    for (int k = 0; k < 3; k++) begin
      push_valid = 1'b1; push_data = 8'(8'hD1 + k); tick();
    end
    push_valid = 1'b0;
    @(negedge clk); chk("pre_sir_valid", 32'(pop_valid), 32'd1);
    tick();
    push_sender_in_reset = 1'b1; pop_ready = 1'b1;
    @(negedge clk);
    chk("sir_pop_valid", 32'(pop_valid), 32'd0);
    chk("sir_credit", 32'(push_credit), 32'd0);
    chk("sir_recv_rst", 32'(push_receiver_in_reset), 32'd0);
    tick();
    push_sender_in_reset = 1'b0;
    @(negedge clk);
    chk("sir_count", 32'(credit_count), 32'd4);
    chk("sir_empty", 32'(pop_valid), 32'd0);
    tick();
    credit_withhold = '0;
    repeat (6) tick();

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
